// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave
//   AHB-Lite slave that fronts a single-ported synchronous SRAM. Every legal
//   transfer is stretched by WAIT_STATES HReady-low cycles followed by one
//   HReady-high data cycle. Misaligned or oversized transfers get the
//   two-cycle ERROR response and never touch the memory.
//
// Parameters
//   WAIT_STATES : HReady-low cycles per OKAY transfer (1..15)
//   ADDR_BITS   : width of the SRAM word address
//
// Ports
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   HSel            : slave select from the bus decoder
//   HAddress        : address-phase byte address
//   HTrans          : transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HSize           : transfer size (byte/half/word)
//   HWrite          : 1 = write, 0 = read
//   HWrite_data     : write data, valid in the data phase
//   HRead_data      : read data, zero outside read data cycles
//   HReady          : transfer done / accept qualifier
//   HResp           : 00 OKAY, 01 ERROR
//   mem_cs, mem_we  : SRAM chip select and byte write enables
//   mem_addr        : SRAM word address (latched HAddress[ADDR_BITS+1:2])
//   mem_wdata       : SRAM write data
//   mem_rdata       : SRAM read data, valid one cycle after a read select

`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_SIZE_BITS
`define AHB_SIZE_BITS 3
`endif

module ahb_mem_slave #(
   parameter int WAIT_STATES = 1,
   parameter int ADDR_BITS   = 14
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        HSel,
   input  logic [31:0]                 HAddress,
   input  logic [`AHB_TRANS_BITS-1:0]  HTrans,
   input  logic [`AHB_SIZE_BITS-1:0]   HSize,
   input  logic                        HWrite,
   input  logic [31:0]                 HWrite_data,
   output logic [31:0]                 HRead_data,
   output logic                        HReady,
   output logic [1:0]                  HResp,
   output logic                        mem_cs,
   output logic [3:0]                  mem_we,
   output logic [ADDR_BITS-1:0]        mem_addr,
   output logic [31:0]                 mem_wdata,
   input  logic [31:0]                 mem_rdata
);

   typedef enum logic [2:0] {
      stIdle,
      stWait,
      stData,
      stErr1,
      stErr2
   } stateType;

   localparam logic [3:0] waitLoad = 4'(WAIT_STATES);

   stateType               state;
   stateType               nextState;
   logic [3:0]             waitCount;
   logic [ADDR_BITS+1:0]   addrReg;
   logic                   writeReg;
   logic [2:0]             sizeReg;
   logic                   accept;
   logic                   badTransfer;
   logic                   lastWait;
   logic                   readSelect;
   logic                   writeSelect;
   logic [3:0]             laneMask;
   logic                   unusedBits;

   // Address bits above the memory window and HTrans[0] (NONSEQ vs SEQ) do
   // not influence this slave; they are folded here so nothing dangles.
   assign unusedBits = ^{HAddress[31:ADDR_BITS+2], HTrans[0]};

   // HReady is purely a function of state: low only while a transfer is
   // being stretched (WAIT) or in the first ERROR cycle. Because it depends
   // on the state flops alone, reset forces it high immediately.
   always_comb begin
      HReady = 1'b1;
      HResp  = 2'b00;
      case (state)
         stWait:  HReady = 1'b0;
         stErr1: begin
            HReady = 1'b0;
            HResp  = 2'b01;
         end
         stErr2:  HResp  = 2'b01;
         default: begin
            HReady = 1'b1;
            HResp  = 2'b00;
         end
      endcase
   end

   // A new transfer is taken whenever we are selected with NONSEQ/SEQ and
   // our own HReady is high, which covers both the idle case and the
   // pipelined address arriving during a DATA or ERR2 cycle. Misalignment
   // and unsupported sizes are judged on the incoming address phase so the
   // very next state is already the ERROR path.
   always_comb begin
      accept      = HSel && HTrans[1] && HReady;
      badTransfer = (HSize > 3'b010)
                 || ((HSize == 3'b001) && HAddress[0])
                 || ((HSize == 3'b010) && (HAddress[1:0] != 2'b00));
   end

   // Next-state logic. WAIT runs until the counter reaches 1, giving exactly
   // WAIT_STATES low cycles before the single DATA cycle.
   always_comb begin
      nextState = state;
      case (state)
         stIdle, stData, stErr2: begin
            if (accept) begin
               nextState = badTransfer ? stErr1 : stWait;
            end else begin
               nextState = stIdle;
            end
         end
         stWait: begin
            if (lastWait) begin
               nextState = stData;
            end
         end
         stErr1:  nextState = stErr2;
         default: nextState = stIdle;
      endcase
   end

   // State, wait counter and the latched address-phase controls. The
   // counter is loaded only for transfers heading into WAIT, and the address
   // controls are captured on every accept so the lane mask and SRAM address
   // stay stable for the whole data phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= stIdle;
         waitCount <= 4'd0;
         addrReg   <= '0;
         writeReg  <= 1'b0;
         sizeReg   <= 3'b000;
      end else begin
         state <= nextState;
         if (accept && !badTransfer) begin
            waitCount <= waitLoad;
         end else if (state == stWait) begin
            waitCount <= waitCount - 4'd1;
         end
         if (accept) begin
            addrReg  <= HAddress[ADDR_BITS+1:0];
            writeReg <= HWrite;
            sizeReg  <= HSize;
         end
      end
   end

   // Byte-lane enables for writes, derived from the latched size and the
   // two low address bits.
   always_comb begin
      laneMask = 4'b0000;
      case (sizeReg)
         3'b000:  laneMask = 4'b0001 << addrReg[1:0];
         3'b001:  laneMask = addrReg[1] ? 4'b1100 : 4'b0011;
         3'b010:  laneMask = 4'b1111;
         default: laneMask = 4'b0000;
      endcase
   end

   // SRAM and read-data drive. Reads select the SRAM in the last WAIT cycle
   // so its one-cycle latency lands the word exactly on the DATA cycle;
   // writes select it in the DATA cycle when HWrite_data is valid. Outside
   // those windows everything is held at zero, and ERROR transfers never
   // reach either window.
   always_comb begin
      lastWait    = (state == stWait) && (waitCount <= 4'd1);
      readSelect  = lastWait && !writeReg;
      writeSelect = (state == stData) && writeReg;
      mem_cs      = readSelect || writeSelect;
      mem_we      = writeSelect ? laneMask : 4'b0000;
      mem_addr    = addrReg[ADDR_BITS+1:2];
      mem_wdata   = writeSelect ? HWrite_data : 32'h0000_0000;
      HRead_data  = ((state == stData) && !writeReg) ? mem_rdata : 32'h0000_0000;
   end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb_ahb_mem_slave
//   Drives two instances of ahb_mem_slave (WAIT_STATES=1 and WAIT_STATES=3)
//   from one shared AHB master, each backed by its own synchronous SRAM.
//   Expected behaviour comes from a byte-addressed reference memory and the
//   transfer rules (alignment, lane masks, wait-cycle counts).

module tb_ahb_mem_slave;

   localparam logic [1:0] TrIdle   = 2'b00;
   localparam logic [1:0] TrBusy   = 2'b01;
   localparam logic [1:0] TrNonseq = 2'b10;
   localparam logic [2:0] SzByte   = 3'b000;
   localparam logic [2:0] SzHalf   = 3'b001;
   localparam logic [2:0] SzWord   = 3'b010;

   logic        clk;
   logic        rst;
   logic        clearMem;
   logic        hSel1;
   logic        hSel3;
   logic [31:0] hAddress;
   logic [1:0]  hTrans;
   logic [2:0]  hSize;
   logic        hWrite;
   logic [31:0] hWriteData;

   logic [31:0] rdata1, rdata3;
   logic        ready1, ready3;
   logic [1:0]  resp1, resp3;
   logic        cs1, cs3;
   logic [3:0]  we1, we3;
   logic [13:0] addr1, addr3;
   logic [31:0] wdata1, wdata3;
   logic [31:0] memRdata1, memRdata3;

   logic [31:0] sram1 [0:63];
   logic [31:0] sram3 [0:63];
   logic [7:0]  modelMem [0:1][0:255];

   int testsRun;
   int failCount;

   ahb_mem_slave #(.WAIT_STATES(1), .ADDR_BITS(14)) dut1 (
      .clk(clk), .rst(rst), .HSel(hSel1), .HAddress(hAddress), .HTrans(hTrans),
      .HSize(hSize), .HWrite(hWrite), .HWrite_data(hWriteData),
      .HRead_data(rdata1), .HReady(ready1), .HResp(resp1), .mem_cs(cs1),
      .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1), .mem_rdata(memRdata1)
   );

   ahb_mem_slave #(.WAIT_STATES(3), .ADDR_BITS(14)) dut3 (
      .clk(clk), .rst(rst), .HSel(hSel3), .HAddress(hAddress), .HTrans(hTrans),
      .HSize(hSize), .HWrite(hWrite), .HWrite_data(hWriteData),
      .HRead_data(rdata3), .HReady(ready3), .HResp(resp3), .mem_cs(cs3),
      .mem_we(we3), .mem_addr(addr3), .mem_wdata(wdata3), .mem_rdata(memRdata3)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM behind the WAIT_STATES=1 slave: byte-enabled writes, registered
   // read data one cycle after a read select.
   always @(posedge clk) begin
      if (clearMem) begin
         for (int w = 0; w < 64; w++) sram1[w] <= 32'h0;
         memRdata1 <= 32'h0;
      end else if (cs1) begin
         if (we1 != 4'b0000) begin
            for (int b = 0; b < 4; b++)
               if (we1[b]) sram1[addr1[5:0]][b*8 +: 8] <= wdata1[b*8 +: 8];
         end else begin
            memRdata1 <= sram1[addr1[5:0]];
         end
      end
   end

   // SRAM behind the WAIT_STATES=3 slave, identical behaviour.
   always @(posedge clk) begin
      if (clearMem) begin
         for (int w = 0; w < 64; w++) sram3[w] <= 32'h0;
         memRdata3 <= 32'h0;
      end else if (cs3) begin
         if (we3 != 4'b0000) begin
            for (int b = 0; b < 4; b++)
               if (we3[b]) sram3[addr3[5:0]][b*8 +: 8] <= wdata3[b*8 +: 8];
         end else begin
            memRdata3 <= sram3[addr3[5:0]];
         end
      end
   end

   // Watchdog so a stuck DUT can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] readWord(input int which, input logic [31:0] addr);
      int base;
      base = int'({addr[7:2], 2'b00});
      return {modelMem[which][base+3], modelMem[which][base+2],
              modelMem[which][base+1], modelMem[which][base]};
   endfunction

   // One complete non-pipelined transfer, entered and left just after a
   // rising edge. Everything observed at the falling edges of the data
   // phase is summarised for the caller.
   task automatic applyStimulus(input int which, input logic [1:0] trans,
                                input logic [31:0] addr, input logic wr,
                                input logic [2:0] size, input logic [31:0] wdata,
                                output int lowCycles, output logic [1:0] lowResp,
                                output logic [1:0] lastResp, output logic [31:0] lastRdata,
                                output logic [3:0] lastWe, output logic [31:0] lastWdata,
                                output int csCount, output int csCycle,
                                output logic [13:0] csAddr, output logic timedOut);
      logic done;
      logic rdy, cs;
      hSel1 = (which == 0);
      hSel3 = (which == 1);
      hTrans = trans;
      hAddress = addr;
      hWrite = wr;
      hSize = size;
      @(posedge clk); #1;
      hSel1 = 1'b0;
      hSel3 = 1'b0;
      hTrans = TrIdle;
      hAddress = $urandom;
      hWriteData = wdata;
      lowCycles = 0; lowResp = 2'b00; lastResp = 2'b00; lastRdata = 32'h0;
      lastWe = 4'h0; lastWdata = 32'h0; csCount = 0; csCycle = -1; csAddr = 14'h0;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         rdy = (which == 0) ? ready1 : ready3;
         cs  = (which == 0) ? cs1 : cs3;
         if (cs) begin
            csCount++;
            csCycle = i;
            csAddr = (which == 0) ? addr1 : addr3;
         end
         if (rdy) begin
            done = 1'b1;
            lastResp  = (which == 0) ? resp1 : resp3;
            lastRdata = (which == 0) ? rdata1 : rdata3;
            lastWe    = (which == 0) ? we1 : we3;
            lastWdata = (which == 0) ? wdata1 : wdata3;
         end else begin
            lowCycles++;
            lowResp |= (which == 0) ? resp1 : resp3;
         end
         @(posedge clk); #1;
      end
      hWriteData = $urandom;
      timedOut = !done;
   endtask

   // Runs a transfer and judges it against the reference rules, updating the
   // reference memory for legal writes.
   task automatic runAndCheck(input int which, input logic [1:0] trans,
                              input logic [31:0] addr, input logic wr,
                              input logic [2:0] size, input logic [31:0] wdata);
      int ws, lowCycles, csCount, csCycle;
      logic [1:0] lowResp, lastResp;
      logic [31:0] lastRdata, lastWdata, expRdata;
      logic [3:0] lastWe, mask;
      logic [13:0] csAddr;
      logic timedOut, legal;
      ws = (which == 0) ? 1 : 3;
      legal = (size == SzByte) || (size == SzHalf && !addr[0])
           || (size == SzWord && addr[1:0] == 2'b00);
      mask = (size == SzByte) ? (4'b0001 << addr[1:0])
           : (size == SzHalf) ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      expRdata = readWord(which, addr);
      applyStimulus(which, trans, addr, wr, size, wdata, lowCycles, lowResp, lastResp,
                    lastRdata, lastWe, lastWdata, csCount, csCycle, csAddr, timedOut);
      checkOutput("timeout", {31'b0, timedOut}, 32'h0);
      if (!trans[1]) begin
         checkOutput("idleLow", lowCycles, 0);
         checkOutput("idleResp", {30'b0, lastResp}, 32'h0);
         checkOutput("idleCs", csCount, 0);
         checkOutput("idleRdata", lastRdata, 32'h0);
      end else if (!legal) begin
         checkOutput("errLow", lowCycles, 1);
         checkOutput("errLowResp", {30'b0, lowResp}, 32'h1);
         checkOutput("errResp", {30'b0, lastResp}, 32'h1);
         checkOutput("errCs", csCount, 0);
         checkOutput("errWe", {28'b0, lastWe}, 32'h0);
         checkOutput("errRdata", lastRdata, 32'h0);
      end else begin
         checkOutput("okLow", lowCycles, ws);
         checkOutput("okLowResp", {30'b0, lowResp}, 32'h0);
         checkOutput("okResp", {30'b0, lastResp}, 32'h0);
         checkOutput("okCsCount", csCount, 1);
         checkOutput("okCsCycle", csCycle, wr ? ws : ws - 1);
         checkOutput("okMemAddr", {18'b0, csAddr}, {18'b0, addr[15:2]});
         if (wr) begin
            checkOutput("writeWe", {28'b0, lastWe}, {28'b0, mask});
            checkOutput("writeWdata", lastWdata, wdata);
            checkOutput("writeRdata", lastRdata, 32'h0);
            for (int b = 0; b < 4; b++)
               if (mask[b]) modelMem[which][int'({addr[7:2], 2'b00}) + b] = wdata[b*8 +: 8];
         end else begin
            checkOutput("readData", lastRdata, expRdata);
            checkOutput("readWe", {28'b0, lastWe}, 32'h0);
         end
      end
   endtask

   initial begin
      logic [1:0] rTrans;
      logic [2:0] rSize;
      logic [31:0] rAddr;
      int rWhich;
      testsRun = 0;
      failCount = 0;
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < 256; a++) modelMem[d][a] = 8'h00;
      rst = 1'b1;
      clearMem = 1'b1;
      hSel1 = 1'b0; hSel3 = 1'b0; hAddress = 32'h0; hTrans = TrIdle;
      hSize = SzWord; hWrite = 1'b0; hWriteData = 32'h0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstReady1", {31'b0, ready1}, 32'h1);
      checkOutput("rstResp1", {30'b0, resp1}, 32'h0);
      checkOutput("rstRdata1", rdata1, 32'h0);
      checkOutput("rstCs1", {31'b0, cs1}, 32'h0);
      checkOutput("rstWe1", {28'b0, we1}, 32'h0);
      checkOutput("rstReady3", {31'b0, ready3}, 32'h1);
      rst = 1'b0;
      clearMem = 1'b0;
      @(posedge clk); #1;

      // Word write then read back at one wait state.
      runAndCheck(0, TrNonseq, 32'h0000_0010, 1'b1, SzWord, 32'hDEAD_BEEF);
      runAndCheck(0, TrNonseq, 32'h0000_0010, 1'b0, SzWord, 32'h0);

      // Byte write to the top lane, then upper-half write, then read.
      runAndCheck(0, TrNonseq, 32'h0000_0013, 1'b1, SzByte, 32'hAA00_0000);
      runAndCheck(0, TrNonseq, 32'h0000_0012, 1'b1, SzHalf, 32'h1234_5678);
      runAndCheck(0, TrNonseq, 32'h0000_0010, 1'b0, SzWord, 32'h0);

      // Misaligned word read and an unsupported size both get ERROR.
      runAndCheck(0, TrNonseq, 32'h0000_0002, 1'b0, SzWord, 32'h0);
      runAndCheck(1, TrNonseq, 32'h0000_0020, 1'b1, 3'b011, 32'hFFFF_FFFF);
      runAndCheck(1, TrNonseq, 32'h0000_0021, 1'b1, SzHalf, 32'hFFFF_FFFF);

      // BUSY while selected is a zero-wait OKAY.
      runAndCheck(0, TrBusy, 32'h0000_0010, 1'b0, SzWord, 32'h0);

      // Back-to-back reads at three wait states: 3 low + 1 high each.
      runAndCheck(1, TrNonseq, 32'h0000_0020, 1'b1, SzWord, $urandom);
      runAndCheck(1, TrNonseq, 32'h0000_0024, 1'b1, SzWord, $urandom);
      hSel3 = 1'b1; hTrans = TrNonseq; hAddress = 32'h0000_0020;
      hWrite = 1'b0; hSize = SzWord;
      @(posedge clk); #1;
      hAddress = 32'h0000_0024;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checkOutput("pipeReady", {31'b0, ready3}, (i % 4 == 3) ? 32'h1 : 32'h0);
         if (i == 3) checkOutput("pipeDataA", rdata3, readWord(1, 32'h20));
         if (i == 7) checkOutput("pipeDataB", rdata3, readWord(1, 32'h24));
         @(posedge clk); #1;
         if (i == 3) begin
            hSel3 = 1'b0;
            hTrans = TrIdle;
         end
      end

      // Reset asserted in the middle of a WAIT cycle.
      hSel1 = 1'b1; hTrans = TrNonseq; hAddress = 32'h0000_0010;
      hWrite = 1'b0; hSize = SzWord;
      @(posedge clk); #1;
      hSel1 = 1'b0; hTrans = TrIdle;
      checkOutput("waitReady", {31'b0, ready1}, 32'h0);
      #1 rst = 1'b1;
      #1;
      checkOutput("midRstReady", {31'b0, ready1}, 32'h1);
      checkOutput("midRstCs", {31'b0, cs1}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      runAndCheck(0, TrNonseq, 32'h0000_0010, 1'b0, SzWord, 32'h0);

      // Randomised transfers on both slaves, judged by the reference rules.
      for (int n = 0; n < 24; n++) begin
         rWhich = int'($urandom_range(0, 1));
         rSize = 3'($urandom_range(0, 3));
         rAddr = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) begin
            if (rSize == SzHalf) rAddr[0] = 1'b0;
            if (rSize == SzWord) rAddr[1:0] = 2'b00;
         end
         rTrans = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 4) != 0) rTrans[1] = 1'b1;
         runAndCheck(rWhich, rTrans, rAddr, 1'($urandom_range(0, 1)), rSize, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/ahb_mem_slave.md
AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, meaning HReady-low cycles inserted per OKAY transfer (legal range 1..15).
REQ-002 SHALL have parameter ADDR_BITS, default 14, meaning the width of the memory word address.
REQ-003 SHALL have port clk, input, 1, the single clock; all flops are on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port HSel, input, 1, slave select from the bus decoder.
REQ-006 SHALL have port HAddress, input, 32, address-phase address.
REQ-007 SHALL have port HTrans, input, `AHB_TRANS_BITS, transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-008 SHALL have port HSize, input, `AHB_SIZE_BITS, transfer size: 000 byte, 001 half, 010 word.
REQ-009 SHALL have port HWrite, input, 1, 1 for write, 0 for read.
REQ-010 SHALL have port HWrite_data, input, 32, write data, valid in the data phase.
REQ-011 SHALL have port HRead_data, output, 32, read data.
REQ-012 SHALL have port HReady, output, 1, transfer done; also the accept qualifier.
REQ-013 SHALL have port HResp, output, 2, response: 00 OKAY, 01 ERROR.
REQ-014 SHALL have port mem_cs, output, 1, SRAM chip select.
REQ-015 SHALL have port mem_we, output, 4, SRAM byte write enables.
REQ-016 SHALL have port mem_addr, output, ADDR_BITS, SRAM word address = HAddress[ADDR_BITS+1:2] as latched.
REQ-017 SHALL have port mem_wdata, output, 32, SRAM write data.
REQ-018 SHALL have port mem_rdata, input, 32, SRAM read data, valid one cycle after a read select.

Function
REQ-019 SHALL accept a transfer on a rising edge where HSel=1, HTrans[1]=1 and HReady=1, latching address, HWrite and HSize.
REQ-020 SHALL give HSel with IDLE/BUSY HTrans, or HSel=0, a zero-wait OKAY with no memory access.
REQ-021 SHALL implement states IDLE, WAIT, DATA, ERR1, ERR2.
REQ-022 SHALL go from an accept to ERR1 if misaligned (half with addr[0]=1; word with addr[1:0]!=0) or if HSize>010, and otherwise to WAIT with the counter loaded to WAIT_STATES.
REQ-023 SHALL, in WAIT, hold HReady=0 and HResp=OKAY, decrement the counter, and go to DATA when the counter reaches 1.
REQ-024 SHALL, for a read, assert mem_cs=1, mem_we=0 and mem_addr in the final WAIT cycle only.
REQ-025 SHALL, in DATA, drive HReady=1 and HResp=OKAY; a read returns HRead_data=mem_rdata, and a write asserts mem_cs=1, mem_we=lane mask and mem_wdata=HWrite_data.
REQ-026 SHALL use lane masks: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100; word 1111.
REQ-027 SHALL give OKAY transfers a data-phase length of exactly WAIT_STATES+1 cycles.
REQ-028 SHALL, in ERR1, drive HReady=0 and HResp=01; in ERR2, drive HReady=1 and HResp=01; no mem_cs in either state.
REQ-029 SHALL, in DATA or ERR2, accept a pipelined transfer per REQ-019/022 (back-to-back), else return to IDLE.
REQ-030 SHALL drive HRead_data=0 outside read DATA cycles, and mem_cs=0, mem_we=0 outside REQ-024/025.
REQ-031 SHALL ignore HWrite_data outside the write DATA cycle and never write memory on an ERROR transfer.

Reset
REQ-032 SHALL, while rst=1 and immediately on assertion even mid-transfer, set state=IDLE, counter=0, HReady=1, HResp=00, HRead_data=0, mem_cs=0 and mem_we=0; the aborted transfer is not completed.

Verification
REQ-033 SHALL pass: word write 0x0000_0010 data 0xDEADBEEF, then read, at WAIT_STATES=1 -> write DATA mem_we=1111 mem_addr=4; read HReady low 1 cycle, then HRead_data=0xDEADBEEF.
REQ-034 SHALL pass: byte write addr 0x13 data 0xAA000000, then half write addr 0x12 -> mem_we=1000 then 1100.
REQ-035 SHALL pass: word read addr 0x2 -> HReady 0,1 with HResp=01 both cycles, and mem_cs never asserted.
REQ-036 SHALL pass: back-to-back NONSEQ reads at WAIT_STATES=3 -> each data phase 3 low + 1 high, with no idle cycle between.
REQ-037 SHALL pass: HTrans=BUSY with HSel=1 -> HReady=1, HResp=00, no mem_cs.
REQ-038 SHALL pass: rst asserted during WAIT -> HReady=1 and mem_cs=0 before the next clock edge; a following read behaves per REQ-033.
